// File: rtl/uart_cmd_ctrl.sv
// UART command-frame controller: hunts SYNC, collects SYNC/CMD/ADDR/DATA/CHK, issues one register strobe.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        ISSUE
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] addr_buf_q, addr_buf_d;
    logic [7:0] data_buf_q, data_buf_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] chk_calc;

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_err_q, timeout_err_d;
`endif

    assign chk_calc = cmd_q ^ addr_buf_q ^ data_buf_q;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_buf_d  = addr_buf_q;
        data_buf_d  = data_buf_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        frame_cnt_d = frame_cnt_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            // ISSUE lasts one cycle and treats a byte arriving in it as a hunt byte
            WAIT_SYNC, ISSUE: begin
                if (rx_done && (rx_data == SYNC_BYTE)) begin
                    state_d = GET_CMD;
                end else begin
                    state_d = WAIT_SYNC;
                end
            end
            GET_CMD: begin
                if (rx_done) begin
                    if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
                        cmd_d   = rx_data;
                        state_d = GET_ADDR;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_SYNC;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_done) begin
                    addr_buf_d = rx_data;
                    state_d    = GET_DATA;
                end
            end
            GET_DATA: begin
                if (rx_done) begin
                    data_buf_d = rx_data;
                    state_d    = GET_CHK;
                end
            end
            GET_CHK: begin
                if (rx_done) begin
                    if (rx_data == chk_calc) begin
                        // Outputs load on the edge entering ISSUE so they are valid during it
                        reg_addr_d  = addr_buf_q;
                        reg_wdata_d = data_buf_q;
                        wr_en_d     = (cmd_q == CMD_WRITE);
                        rd_en_d     = (cmd_q == CMD_READ);
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = ISSUE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_SYNC;
                    end
                end
            end
            default: state_d = WAIT_SYNC;
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        timeout_err_d = 1'b0;
        if ((state_q == WAIT_SYNC) || rx_done) begin
            tmo_cnt_d = 16'd0;
        end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_cnt_d     = 16'd0;
            timeout_err_d = 1'b1;
            state_d       = WAIT_SYNC;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_SYNC;
            cmd_q       <= 8'd0;
            addr_buf_q  <= 8'd0;
            data_buf_q  <= 8'd0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 8'd0;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_cnt_q     <= 16'd0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_buf_q  <= addr_buf_d;
            data_buf_q  <= data_buf_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_en_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != WAIT_SYNC);

`ifdef UART_CMD_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: frame-level byte-queue model compared every cycle, plus literal checks.
module tb_uart_cmd_ctrl;

    localparam int         T    = 12;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_CMD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       reg_wr_en, reg_rd_en, frame_err, timeout_err, busy;
    logic [7:0] reg_addr, reg_wdata, frame_cnt;

    int vectors     = 0;
    int miscompares = 0;

    uart_cmd_ctrl #(
        .TIMEOUT_CYCLES(16'(T)),
        .SYNC_BYTE     (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_en  (reg_rd_en),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Model: the partial frame is a byte queue; empty queue means hunting for SYNC.
    logic [7:0] m_buf[$];
    int         m_idle  = 0;
    bit         m_valid = 1'b0;
    logic [7:0] e_addr, e_wdata, e_cnt;
    logic       e_wr, e_rd, e_ferr, e_terr, e_busy;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_buf.delete();
                m_idle = 0;
                e_addr = 8'd0; e_wdata = 8'd0; e_cnt = 8'd0;
                e_wr = 1'b0; e_rd = 1'b0; e_ferr = 1'b0; e_terr = 1'b0; e_busy = 1'b0;
                m_valid = 1'b1;
            end else begin
                e_wr = 1'b0; e_rd = 1'b0; e_ferr = 1'b0; e_terr = 1'b0;
                if (rx_done) begin
                    m_idle = 0;
                    if (m_buf.size() == 0) begin
                        if (rx_data == SYNC) m_buf.push_back(rx_data);
                    end else begin
                        m_buf.push_back(rx_data);
                        if (m_buf.size() == 2 && !(rx_data == 8'h01 || rx_data == 8'h02)) begin
                            e_ferr = 1'b1;
                            m_buf.delete();
                        end else if (m_buf.size() == 5) begin
                            if ((m_buf[1] ^ m_buf[2] ^ m_buf[3]) == m_buf[4]) begin
                                e_addr  = m_buf[2];
                                e_wdata = m_buf[3];
                                e_wr    = (m_buf[1] == 8'h01);
                                e_rd    = (m_buf[1] == 8'h02);
                                e_cnt   = e_cnt + 8'd1;
                            end else begin
                                e_ferr = 1'b1;
                            end
                            m_buf.delete();
                        end
                    end
                end else if (TMO_EN && m_buf.size() != 0) begin
                    m_idle++;
                    if (m_idle == T) begin
                        e_terr = 1'b1;
                        m_buf.delete();
                        m_idle = 0;
                    end
                end
                e_busy = (m_buf.size() != 0) || e_wr || e_rd;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                vectors++;
                if (reg_wr_en !== e_wr) begin miscompares++; $display("FAIL cyc reg_wr_en got %b exp %b t=%0t", reg_wr_en, e_wr, $time); end
                if (reg_rd_en !== e_rd) begin miscompares++; $display("FAIL cyc reg_rd_en got %b exp %b t=%0t", reg_rd_en, e_rd, $time); end
                if (reg_addr !== e_addr) begin miscompares++; $display("FAIL cyc reg_addr got %h exp %h t=%0t", reg_addr, e_addr, $time); end
                if (reg_wdata !== e_wdata) begin miscompares++; $display("FAIL cyc reg_wdata got %h exp %h t=%0t", reg_wdata, e_wdata, $time); end
                if (frame_err !== e_ferr) begin miscompares++; $display("FAIL cyc frame_err got %b exp %b t=%0t", frame_err, e_ferr, $time); end
                if (timeout_err !== e_terr) begin miscompares++; $display("FAIL cyc timeout_err got %b exp %b t=%0t", timeout_err, e_terr, $time); end
                if (busy !== e_busy) begin miscompares++; $display("FAIL cyc busy got %b exp %b t=%0t", busy, e_busy, $time); end
                if (frame_cnt !== e_cnt) begin miscompares++; $display("FAIL cyc frame_cnt got %0d exp %0d t=%0t", frame_cnt, e_cnt, $time); end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h exp %h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic send_now(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 send_now(b);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k);
        send(SYNC); send(c); send(a); send(d); send(k);
    endtask

    initial begin
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_addr", 16'(reg_addr), 16'h00);
        chk("reset_cnt", 16'(frame_cnt), 16'h00);
        chk("reset_busy", 16'(busy), 16'h0);

        frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        chk("wr_strobe", 16'(reg_wr_en), 16'h1);
        chk("wr_no_rd", 16'(reg_rd_en), 16'h0);
        chk("wr_addr", 16'(reg_addr), 16'h10);
        chk("wr_wdata", 16'(reg_wdata), 16'h3C);
        chk("wr_cnt", 16'(frame_cnt), 16'h01);
        @(posedge clk); #1 chk("wr_one_cycle", 16'(reg_wr_en), 16'h0);

        frame(8'h02, 8'h20, 8'h00, 8'h22);
        chk("rd_strobe", 16'(reg_rd_en), 16'h1);
        chk("rd_no_wr", 16'(reg_wr_en), 16'h0);
        chk("rd_addr", 16'(reg_addr), 16'h20);

        frame(8'h01, 8'h10, 8'h3C, 8'h00);
        chk("badchk_ferr", 16'(frame_err), 16'h1);
        chk("badchk_no_wr", 16'(reg_wr_en), 16'h0);
        chk("badchk_addr_held", 16'(reg_addr), 16'h20);
        @(posedge clk); #1 chk("ferr_one_cycle", 16'(frame_err), 16'h0);
        frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        chk("after_bad_wr", 16'(reg_wr_en), 16'h1);
        chk("after_bad_cnt", 16'(frame_cnt), 16'h03);

        send(8'h00); send(8'hFF); send(8'h5A);
        chk("garbage_busy", 16'(busy), 16'h0);
        frame(8'h01, 8'h44, 8'h55, 8'h10);
        chk("garbage_then_wr", 16'(reg_wr_en), 16'h1);
        chk("garbage_then_addr", 16'(reg_addr), 16'h44);

        send(SYNC); send(8'h07);
        chk("badcmd_ferr", 16'(frame_err), 16'h1);
        chk("badcmd_busy", 16'(busy), 16'h0);
        send(SYNC); send(SYNC);
        chk("sync_as_cmd_ferr", 16'(frame_err), 16'h1);

        // SYNC arriving in the ISSUE cycle starts the next frame
        frame(8'h01, 8'h12, 8'h34, 8'h27);
        chk("issue_wr", 16'(reg_wr_en), 16'h1);
        send_now(SYNC);
        chk("issue_sync_busy", 16'(busy), 16'h1);
        send(8'h02); send(8'h30); send(8'h77); send(8'h45);
        chk("b2b_rd", 16'(reg_rd_en), 16'h1);
        chk("b2b_wdata", 16'(reg_wdata), 16'h77);
        chk("b2b_cnt", 16'(frame_cnt), 16'h06);

        send(SYNC); send(8'h01);
        if (TMO_EN) begin
            repeat (T) @(posedge clk);
            #1;
            chk("tmo_pulse", 16'(timeout_err), 16'h1);
            chk("tmo_busy", 16'(busy), 16'h0);
            send(SYNC); send(8'h01);
            repeat (T - 1) @(posedge clk);
            #1 send_now(8'h10);
            chk("tmo_race_none", 16'(timeout_err), 16'h0);
            chk("tmo_race_busy", 16'(busy), 16'h1);
        end else begin
            repeat (3 * T) @(posedge clk);
            #1;
            chk("stall_busy", 16'(busy), 16'h1);
            chk("stall_no_tmo", 16'(timeout_err), 16'h0);
            send(8'h10);
        end
        send(8'h3C); send(8'h2D);
        chk("post_stall_wr", 16'(reg_wr_en), 16'h1);
        chk("post_stall_cnt", 16'(frame_cnt), 16'h07);

        send(SYNC); send(8'h01); send(8'h10);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_addr", 16'(reg_addr), 16'h00);
        chk("rst_wdata", 16'(reg_wdata), 16'h00);
        chk("rst_cnt", 16'(frame_cnt), 16'h00);
        chk("rst_busy", 16'(busy), 16'h0);
        send(8'h3C); send(8'h2D);
        chk("rst_tail_no_wr", 16'(reg_wr_en), 16'h0);
        chk("rst_tail_no_ferr", 16'(frame_err), 16'h0);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] c, a, d;
            c = (i % 2 == 0) ? 8'h01 : 8'h02;
            a = 8'(i);
            d = a ^ 8'h5A;
            frame(c, a, d, c ^ a ^ d);
            if (i == 254) chk("cnt_255", 16'(frame_cnt), 16'hFF);
        end
        chk("cnt_wrap", 16'(frame_cnt), 16'h00);
        chk("last_addr", 16'(reg_addr), 16'hFF);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
